// File: rtl/clint_timer.sv
// clint_timer: machine-timer (CLINT mtime) slave on a single-beat AXI4-style port.
//
// Holds a free-running 64-bit cycle counter, exposed as two 32-bit words:
// araddr/awaddr bit 2 selects the word (0 = mtime[31:0], 1 = mtime[63:32]).
// Other address bits are ignored and every access returns OKAY.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ar* / arready_o              read address channel (only arid, araddr[2] used)
//   rid, rdata_o, rresp_o,
//   rvalid_o, rlast_o, rready    read data channel (single beat, rlast_o == rvalid_o)
//   aw* / awready_o              write address channel (only awid, awaddr[2] used)
//   wdata, wstrb, wvalid,
//   wready_o, wlast              write data channel (wlast ignored)
//   bid, bresp_o, bvalid_o,
//   bready                       write response channel
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready_o high, waiting for a read address
//   R_RESP | snapshot held, rvalid_o high until rready
//
// Write FSM
//   state  | meaning
//   B_ARM  | AW and W accepted independently; write applied once both are held
//   B_RESP | write applied, bvalid_o high until bready
module clint_timer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arsize,
  input  logic [7:0]          arlen,
  input  logic [3:0]          arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready_o,
  output logic [3:0]          rid,
  output logic                rlast_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awsize,
  input  logic [7:0]          awlen,
  input  logic [3:0]          awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready_o,
  input  logic                wlast,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready_o,
  output logic [3:0]          bid,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready
);

  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {B_ARM, B_RESP} b_state_t;

  logic [63:0] mtime, mtime_nxt;

  r_state_t r_state, r_next;
  logic [63:0] snap;
  logic        rsel;

  b_state_t b_state, b_next;
  logic              aw_held, w_held, aw_fire, w_fire, apply;
  logic              awsel_q, sel_hi;
  logic [DATA_W-1:0] wdata_q, wd;
  logic [DATA_W/8-1:0] wstrb_q, ws;

  // Request attributes that carry no meaning for a two-word register.
  logic unused_attr;
  assign unused_attr = ^{arburst, arsize, arlen, araddr[ADDR_W-1:3], araddr[1:0],
                         awburst, awsize, awlen, awaddr[ADDR_W-1:3], awaddr[1:0], wlast};

  // ---------------- read path ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid) r_next = R_RESP;
      end
      R_RESP: begin
        rvalid_o = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Snapshot is the pre-increment (and pre-write) value seen in the handshake cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      rsel <= 1'b0;
      rid  <= '0;
    end else if (arvalid && arready_o) begin
      snap <= mtime;
      rsel <= araddr[2];
      rid  <= arid;
    end
  end

  assign rdata_o = rsel ? snap[63:32] : snap[31:0];
  assign rlast_o = rvalid_o;
  assign rresp_o = 2'b00;

  // ---------------- write path ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) b_state <= B_ARM;
    else     b_state <= b_next;
  end

  always_comb begin
    b_next    = b_state;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    case (b_state)
      B_ARM: begin
        awready_o = !aw_held;
        wready_o  = !w_held;
        if (apply) b_next = B_RESP;
      end
      B_RESP: begin
        bvalid_o = 1'b1;
        if (bready) b_next = B_ARM;
      end
      default: b_next = B_ARM;
    endcase
  end

  assign aw_fire = awvalid && awready_o;
  assign w_fire  = wvalid && wready_o;
  // A channel arriving this cycle counts as held so the write lands on the same edge.
  assign apply   = (b_state == B_ARM) && (aw_held || aw_fire) && (w_held || w_fire);
  assign sel_hi  = aw_fire ? awaddr[2] : awsel_q;
  assign wd      = w_fire ? wdata : wdata_q;
  assign ws      = w_fire ? wstrb : wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awsel_q <= 1'b0;
      bid     <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_fire) begin
        awsel_q <= awaddr[2];
        bid     <= awid;
      end
      if (w_fire) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (apply) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
      end
    end
  end

  assign bresp_o = 2'b00;

  // ---------------- counter ----------------
  // Written bytes override the increment; unwritten bytes take mtime+1.
  always_comb begin
    mtime_nxt = mtime + 64'd1;
    if (apply) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (ws[i]) begin
          if (sel_hi) mtime_nxt[32 + 8*i +: 8] = wd[8*i +: 8];
          else        mtime_nxt[8*i +: 8]      = wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtime <= '0;
    else     mtime <= mtime_nxt;
  end

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  arburst = '0, awburst = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [3:0]  arid = '0, awid = '0;
  logic [31:0] araddr = '0, awaddr = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b1;
  logic        rready = 1'b1, bready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        arready_o, rlast_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [3:0]  rid, bid;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o, bresp_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  logic [31:0] anchor_lo;
  int anchor_c;

  localparam logic [31:0] A_LO = 32'h0200_0048;
  localparam logic [31:0] A_HI = 32'h0200_004C;

  clint_timer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .arburst(arburst), .arsize(arsize), .arlen(arlen), .arid(arid),
    .araddr(araddr), .arvalid(arvalid), .arready_o(arready_o),
    .rid(rid), .rlast_o(rlast_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rvalid_o(rvalid_o), .rready(rready),
    .awburst(awburst), .awsize(awsize), .awlen(awlen), .awid(awid),
    .awaddr(awaddr), .awvalid(awvalid), .awready_o(awready_o),
    .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready_o(wready_o),
    .bid(bid), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready(bready)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals mtime while nothing has been written.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    int guard = 0;
    while (cyc < k && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  function automatic logic [31:0] lo_at(input int c);
    return anchor_lo + 32'(c - anchor_c);
  endfunction

  // Single read with rready high; returns the beat and the cycle it was issued in.
  task automatic rd(input logic [31:0] addr, input logic [3:0] id,
                    output logic [31:0] data, output int c_at, output logic rv);
    c_at = cyc;
    araddr = addr; arid = id; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    data = rdata_o;
    rv = rvalid_o;
    tick();
  endtask

  // AW and W presented in the same cycle; c_apply is the cycle index right after the write edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [3:0] id, output int c_apply, output logic bv, output logic [3:0] bidv);
    awaddr = addr; awid = id; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    c_apply = cyc;
    bv = bvalid_o;
    bidv = bid;
    tick();
  endtask

  task automatic test_reset;
    tick(); tick();
    n_checks++; if ({arready_o, awready_o, wready_o} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", {arready_o, awready_o, wready_o}); end
    n_checks++; if ({rvalid_o, rlast_o, bvalid_o} !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", {rvalid_o, rlast_o, bvalid_o}); end
    n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    n_checks++; if ({rid, bid, rresp_o, bresp_o} !== 12'h0) begin n_fail++; $display("FAIL reset_ids_resp: got %h expected 0", {rid, bid, rresp_o, bresp_o}); end
    rst = 1'b0;
    anchor_lo = 32'h0; anchor_c = 0;
  endtask

  task automatic test_read_low;
    wait_until(5);
    araddr = A_LO; arid = 4'h3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL read_low_rvalid: got %b expected 1", rvalid_o); end
    n_checks++; if (rdata_o !== 32'd5) begin n_fail++; $display("FAIL read_low_data: got %h expected %h", rdata_o, 32'd5); end
    n_checks++; if ({rlast_o, rresp_o, rid} !== {1'b1, 2'b00, 4'h3}) begin n_fail++; $display("FAIL read_low_attr: got %b expected 1003", {rlast_o, rresp_o, rid}); end
    n_checks++; if (arready_o !== 1'b0) begin n_fail++; $display("FAIL read_low_arready_busy: got %b expected 0", arready_o); end
    tick();
    n_checks++; if ({rvalid_o, arready_o} !== 2'b01) begin n_fail++; $display("FAIL read_low_return_idle: got %b expected 01", {rvalid_o, arready_o}); end
  endtask

  task automatic test_read_high;
    logic [31:0] d; int c; logic rv;
    rd(A_HI, 4'h5, d, c, rv);
    n_checks++; if ({rv, d} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL read_high_zero: got %b/%h expected 1/0", rv, d); end
  endtask

  task automatic test_carry;
    logic [31:0] d; int c, ca; logic rv, bv; logic [3:0] bi;
    wr(A_HI, 32'h0, 4'hF, 4'h1, ca, bv, bi);
    wr(A_LO, 32'hFFFF_FFFF, 4'hF, 4'h2, ca, bv, bi);
    anchor_lo = 32'hFFFF_FFFF; anchor_c = ca;
    n_checks++; if ({bv, bi} !== {1'b1, 4'h2}) begin n_fail++; $display("FAIL carry_bresp: got %b/%h expected 1/2", bv, bi); end
    tick(); tick(); tick();
    rd(A_HI, 4'h0, d, c, rv);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL carry_high: got %h expected 1", d); end
    rd(A_LO, 4'h0, d, c, rv);
    n_checks++; if (d !== lo_at(c)) begin n_fail++; $display("FAIL carry_low: got %h expected %h", d, lo_at(c)); end
  endtask

  task automatic test_partial_high;
    logic [31:0] d; int c, ca; logic rv, bv; logic [3:0] bi;
    wr(A_HI, 32'hDEAD_BEEF, 4'h3, 4'h9, ca, bv, bi);
    n_checks++; if ({bv, bi} !== {1'b1, 4'h9}) begin n_fail++; $display("FAIL partial_high_bid: got %b/%h expected 1/9", bv, bi); end
    rd(A_HI, 4'h0, d, c, rv);
    n_checks++; if (d !== 32'h0000_BEEF) begin n_fail++; $display("FAIL partial_high_data: got %h expected 0000beef", d); end
  endtask

  // Base ..00FE ticks to ..0100 on the write edge, so byte 1 proves unwritten bytes take mtime+1.
  task automatic test_partial_low;
    logic [31:0] d; int c, ca; logic rv, bv; logic [3:0] bi;
    wr(A_LO, 32'h1000_00FE, 4'hF, 4'h4, ca, bv, bi);
    wr(A_LO, 32'hAAAA_AA77, 4'h1, 4'h4, ca, bv, bi);
    anchor_lo = 32'h1000_0177; anchor_c = ca;
    rd(A_LO, 4'h0, d, c, rv);
    n_checks++; if (d !== lo_at(c)) begin n_fail++; $display("FAIL partial_low_data: got %h expected %h", d, lo_at(c)); end
  endtask

  task automatic test_split_channels;
    logic [31:0] d; int c; logic rv;
    awaddr = A_HI; awid = 4'h6; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_checks++; if ({awready_o, wready_o, bvalid_o} !== 3'b010) begin n_fail++; $display("FAIL aw_first_ready: got %b expected 010", {awready_o, wready_o, bvalid_o}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL aw_first_early_b: got %b expected 0", bvalid_o); end
    end
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_checks++; if ({bvalid_o, bid} !== {1'b1, 4'h6}) begin n_fail++; $display("FAIL aw_first_bvalid: got %b/%h expected 1/6", bvalid_o, bid); end
    tick();
    n_checks++; if ({bvalid_o, awready_o, wready_o} !== 3'b011) begin n_fail++; $display("FAIL aw_first_rearm: got %b expected 011", {bvalid_o, awready_o, wready_o}); end

    wdata = 32'hCAFE_0000; wstrb = 4'hC;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_checks++; if ({awready_o, wready_o, bvalid_o} !== 3'b100) begin n_fail++; $display("FAIL w_first_ready: got %b expected 100", {awready_o, wready_o, bvalid_o}); end
    tick();
    awaddr = A_HI; awid = 4'h7; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_checks++; if ({bvalid_o, bid} !== {1'b1, 4'h7}) begin n_fail++; $display("FAIL w_first_bvalid: got %b/%h expected 1/7", bvalid_o, bid); end
    tick();
    rd(A_HI, 4'h0, d, c, rv);
    n_checks++; if (d !== 32'hCAFE_5678) begin n_fail++; $display("FAIL split_high_data: got %h expected cafe5678", d); end
  endtask

  task automatic test_rready_hold;
    logic [31:0] exp0, d; int c; logic rv;
    rready = 1'b0;
    exp0 = lo_at(cyc);
    araddr = A_LO; arid = 4'hA; arvalid = 1'b1;
    tick();
    araddr = A_HI; arid = 4'hB;  // keep requesting; must not be accepted while busy
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({rvalid_o, arready_o, rid, rdata_o} !== {1'b1, 1'b0, 4'hA, exp0}) begin n_fail++; $display("FAIL hold_cycle%0d: got %b/%b/%h/%h expected 1/0/a/%h", i, rvalid_o, arready_o, rid, rdata_o, exp0); end
      tick();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    n_checks++; if ({rvalid_o, arready_o} !== 2'b01) begin n_fail++; $display("FAIL hold_release: got %b expected 01", {rvalid_o, arready_o}); end
    rd(A_LO, 4'h0, d, c, rv);
    n_checks++; if (d !== lo_at(c) || !(d > exp0)) begin n_fail++; $display("FAIL hold_next_read: got %h expected %h", d, lo_at(c)); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r, d1, d2, d3; int c1, c2, c3; logic rv;
    exp_r = lo_at(cyc);
    araddr = A_LO; arid = 4'h2; arvalid = 1'b1;
    awaddr = A_LO; awid = 4'h3; wdata = 32'h5000_0000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    anchor_lo = 32'h5000_0000; anchor_c = cyc;
    n_checks++; if ({rvalid_o, bvalid_o, rdata_o} !== {1'b1, 1'b1, exp_r}) begin n_fail++; $display("FAIL same_cycle_rw: got %b/%b/%h expected 1/1/%h", rvalid_o, bvalid_o, rdata_o, exp_r); end
    tick();
    rd(A_LO, 4'h0, d1, c1, rv);
    rd(A_LO, 4'h0, d2, c2, rv);
    rd(A_HI, 4'h0, d3, c3, rv);
    n_checks++; if (d1 !== lo_at(c1)) begin n_fail++; $display("FAIL b2b_read1: got %h expected %h", d1, lo_at(c1)); end
    n_checks++; if (d2 !== lo_at(c2)) begin n_fail++; $display("FAIL b2b_read2: got %h expected %h", d2, lo_at(c2)); end
    n_checks++; if (d3 !== 32'hCAFE_5678) begin n_fail++; $display("FAIL b2b_high: got %h expected cafe5678", d3); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; int c; logic rv;
    rready = 1'b0;
    araddr = A_HI; arid = 4'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre: got %b expected 1", rvalid_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({rvalid_o, rlast_o, arready_o, rdata_o, rid} !== {3'b001, 32'h0, 4'h0}) begin n_fail++; $display("FAIL mid_reset_drop: got %b/%h/%h expected 001/0/0", {rvalid_o, rlast_o, arready_o}, rdata_o, rid); end
    tick();
    rst = 1'b0;
    rready = 1'b1;
    wait_until(3);
    rd(A_LO, 4'h0, d, c, rv);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL mid_reset_restart: got %h expected 3", d); end
    rd(A_HI, 4'h0, d, c, rv);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_reset_high: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_read_low();
    test_read_high();
    test_carry();
    test_partial_high();
    test_partial_low();
    test_split_channels();
    test_rready_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
